mem_port_arbiter: RTL and testbench

Shares the single-port instruction/data RAM between the fetch stage (read-only) and the load/store stage (read/write). Sits between both stages and the RAM, grants at most one access per cycle, and routes the registered RAM read data back to the owner of the in-flight read. Makes split instruction/data interfaces run on one RAM port with back-to-back throughput.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the single-port RAM arbiter: request owners, FSM states, byte-enable width.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Who owns a grant or the read currently in flight.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Owner of the response presented in the current cycle.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH_RSP = 2'd1,
    ST_DATA_RSP  = 2'd2
  } state_e;

  // Byte-enable width for a data bus whose MSB index is data_msb.
  function automatic int be_width(input int data_msb);
    return (data_msb + 1) / 8;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker: chooses fetch or data for the single RAM port.
// Latency: purely combinational, zero cycles.
// Backpressure: a losing requester simply sees no grant and keeps its request held.
// MEM_ARB_RR_EN selects round-robin on conflict; otherwise data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   req_f,
  input  logic   req_d,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_grant,
`endif
  output owner_e grant
);

  // Single requester wins outright; on conflict apply the configured policy.
  always_comb begin
    grant = OWN_NONE;
    if (req_f && req_d) begin
`ifdef MEM_ARB_RR_EN
      grant = (last_grant == OWN_DATA) ? OWN_FETCH : OWN_DATA;
`else
      grant = OWN_DATA;
`endif
    end else if (req_f) begin
      grant = OWN_FETCH;
    end else if (req_d) begin
      grant = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch (read-only) and load/store (read/write), one access per cycle.
// Latency: grant combinational in the request cycle, read response one cycle later.
// Backpressure: clk_en=0 freezes everything; losing/flushed requesters hold until granted. MEM_ARB_RR_EN selects round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clk_en,
  input  logic                              i_fetch_req,
  input  logic [ADDR_WIDTH:0]               i_fetch_addr,
  input  logic                              i_fetch_flush,
  output logic                              o_fetch_gnt,
  output logic                              o_fetch_valid,
  output logic [DATA_WIDTH:0]               o_fetch_data,
  input  logic                              i_data_req,
  input  logic                              i_data_we,
  input  logic [ADDR_WIDTH:0]               i_data_addr,
  input  logic [DATA_WIDTH:0]               i_data_wdata,
  input  logic [be_width(DATA_WIDTH)-1:0]   i_data_be,
  output logic                              o_data_gnt,
  output logic                              o_data_valid,
  output logic [DATA_WIDTH:0]               o_data_rdata,
  output logic                              o_ram_en,
  output logic                              o_ram_we,
  output logic [be_width(DATA_WIDTH)-1:0]   o_ram_be,
  output logic [ADDR_WIDTH:0]               o_ram_addr,
  output logic [DATA_WIDTH:0]               o_ram_wdata,
  input  logic [DATA_WIDTH:0]               i_ram_rdata
);

  // Reset also gates outputs so everything reads 0 while rst is held.
  logic   active;
  logic   fetch_elig;
  logic   data_elig;
  owner_e winner;
  state_e state_q;
  state_e state_d;

  assign active     = clk_en & ~rst;
  assign fetch_elig = active & i_fetch_req & ~i_fetch_flush;
  assign data_elig  = active & i_data_req;

`ifdef MEM_ARB_RR_EN
  owner_e last_q;

  // Remember the most recent winner; idle or stalled cycles leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_FETCH;
    end else if (winner != OWN_NONE) begin
      last_q <= winner;
    end
  end

  mem_arb_pick u_pick (
    .req_f      (fetch_elig),
    .req_d      (data_elig),
    .last_grant (last_q),
    .grant      (winner)
  );
`else
  mem_arb_pick u_pick (
    .req_f (fetch_elig),
    .req_d (data_elig),
    .grant (winner)
  );
`endif

  // Track which requester owns the RAM read data arriving next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue the winner to the RAM, route the current response, and pick the next owner.
  always_comb begin
    state_d       = state_q;
    o_fetch_gnt   = 1'b0;
    o_data_gnt    = 1'b0;
    o_fetch_valid = 1'b0;
    o_fetch_data  = '0;
    o_data_valid  = 1'b0;
    o_data_rdata  = '0;
    o_ram_en      = 1'b0;
    o_ram_we      = 1'b0;
    o_ram_be      = '0;
    o_ram_addr    = '0;
    o_ram_wdata   = '0;

    case (winner)
      OWN_FETCH: begin
        o_fetch_gnt = 1'b1;
        o_ram_en    = 1'b1;
        o_ram_be    = '1;
        o_ram_addr  = i_fetch_addr;
      end
      OWN_DATA: begin
        o_data_gnt  = 1'b1;
        o_ram_en    = 1'b1;
        o_ram_we    = i_data_we;
        o_ram_be    = i_data_be;
        o_ram_addr  = i_data_addr;
        o_ram_wdata = i_data_wdata;
      end
      default: ;
    endcase

    // A stalled cycle holds the owner so the response is re-presented later.
    if (active) begin
      case (winner)
        OWN_FETCH: state_d = ST_FETCH_RSP;
        OWN_DATA:  state_d = i_data_we ? ST_IDLE : ST_DATA_RSP;
        default:   state_d = ST_IDLE;
      endcase
    end

    case (state_q)
      ST_FETCH_RSP: begin
        if (active && !i_fetch_flush) begin
          o_fetch_valid = 1'b1;
          o_fetch_data  = i_ram_rdata;
        end
      end
      ST_DATA_RSP: begin
        if (active) begin
          o_data_valid = 1'b1;
          o_data_rdata = i_ram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a registered RAM model and response scoreboard.
// Latency: expects grant in cycle N and read response in N+1.
// Backpressure: exercises conflicts, flush, clk_en stall and async reset mid-response.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        i_fetch_req;
  logic [31:0] i_fetch_addr;
  logic        i_fetch_flush;
  logic        o_fetch_gnt;
  logic        o_fetch_valid;
  logic [31:0] o_fetch_data;
  logic        i_data_req;
  logic        i_data_we;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wdata;
  logic [3:0]  i_data_be;
  logic        o_data_gnt;
  logic        o_data_valid;
  logic [31:0] o_data_rdata;
  logic        o_ram_en;
  logic        o_ram_we;
  logic [3:0]  o_ram_be;
  logic [31:0] o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [31:0] ram_q;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] fetch_q [$];
  logic [31:0] data_q  [$];

  int n_checks;
  int n_pass;

  mem_port_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .i_fetch_req   (i_fetch_req),
    .i_fetch_addr  (i_fetch_addr),
    .i_fetch_flush (i_fetch_flush),
    .o_fetch_gnt   (o_fetch_gnt),
    .o_fetch_valid (o_fetch_valid),
    .o_fetch_data  (o_fetch_data),
    .i_data_req    (i_data_req),
    .i_data_we     (i_data_we),
    .i_data_addr   (i_data_addr),
    .i_data_wdata  (i_data_wdata),
    .i_data_be     (i_data_be),
    .o_data_gnt    (o_data_gnt),
    .o_data_valid  (o_data_valid),
    .o_data_rdata  (o_data_rdata),
    .o_ram_en      (o_ram_en),
    .o_ram_we      (o_ram_we),
    .o_ram_be      (o_ram_be),
    .o_ram_addr    (o_ram_addr),
    .o_ram_wdata   (o_ram_wdata),
    .i_ram_rdata   (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: byte-enabled writes, registered read output that holds when idle.
  always @(posedge clk) begin
    if (o_ram_en) begin
      if (o_ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (o_ram_be[b]) ram[o_ram_addr[9:2]][b*8 +: 8] <= o_ram_wdata[b*8 +: 8];
        end
      end else begin
        ram_q <= ram[o_ram_addr[9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Every presented response must match the oldest expectation of its owner.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_fetch_valid) begin
        if (fetch_q.size() == 0) check("fetch_unexpected", 1, 0);
        else check("fetch_data", o_fetch_data, fetch_q.pop_front());
      end
      if (o_data_valid) begin
        if (data_q.size() == 0) check("data_unexpected", 1, 0);
        else check("data_rdata", o_data_rdata, data_q.pop_front());
      end
    end
  end

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_fetch_req   = 1'b0;
    i_fetch_flush = 1'b0;
    i_data_req    = 1'b0;
    i_data_we     = 1'b0;
    i_data_be     = 4'h0;
    i_data_wdata  = 32'h0;
  endtask

  logic [3:0] exp_d_pat;
  logic [3:0] exp_f_pat;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ram_q    = 32'h0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    ram[64]     = 32'h0000_0013;
    ref_mem[64] = 32'h0000_0013;
    rst          = 1'b1;
    clk_en       = 1'b1;
    i_fetch_addr = 32'h0;
    i_data_addr  = 32'h0;
    idle_inputs();

    // Reset state: bus idle and all outputs zero.
    #2;
    check("rst_ram_en", o_ram_en, 0);
    check("rst_ram_addr", o_ram_addr, 0);
    check("rst_fetch_valid", o_fetch_valid, 0);
    check("rst_data_valid", o_data_valid, 0);
    to_pos();
    to_pos();
    rst = 1'b0;

    // Lone fetch at 0x100.
    i_fetch_req = 1'b1; i_fetch_addr = 32'h100;
    to_neg();
    check("f1_gnt", o_fetch_gnt, 1);
    check("f1_ram_we", o_ram_we, 0);
    check("f1_ram_be", o_ram_be, 4'hF);
    check("f1_ram_addr", o_ram_addr, 32'h100);
    fetch_q.push_back(ref_mem[64]);
    to_pos();
    i_fetch_req = 1'b0;
    to_neg();
    check("f1_valid", o_fetch_valid, 1);
    check("f1_idle_ram_en", o_ram_en, 0);

    // Byte-enabled write to 0x200, then read it back.
    to_pos();
    i_data_req = 1'b1; i_data_we = 1'b1; i_data_addr = 32'h200;
    i_data_wdata = 32'hDEAD_BEEF; i_data_be = 4'b0011;
    to_neg();
    check("w_gnt", o_data_gnt, 1);
    check("w_ram_we", o_ram_we, 1);
    check("w_ram_be", o_ram_be, 4'b0011);
    check("w_ram_wdata", o_ram_wdata, 32'hDEAD_BEEF);
    ref_mem[128] = {ref_mem[128][31:16], 16'hBEEF};
    to_pos();
    idle_inputs();
    to_neg();
    check("w_no_valid", o_data_valid, 0);
    to_pos();
    i_data_req = 1'b1; i_data_addr = 32'h200;
    to_neg();
    check("rb_gnt", o_data_gnt, 1);
    data_q.push_back(ref_mem[128]);
    to_pos();
    idle_inputs();
    to_neg();
    check("rb_valid", o_data_valid, 1);

    // Prime the last grant to fetch, then hold both requests for four cycles.
    to_pos();
    i_fetch_req = 1'b1; i_fetch_addr = 32'h104;
    to_neg();
    check("prime_gnt", o_fetch_gnt, 1);
    fetch_q.push_back(ref_mem[65]);
`ifdef MEM_ARB_RR_EN
    exp_d_pat = 4'b0101;
    exp_f_pat = 4'b1010;
`else
    exp_d_pat = 4'b1111;
    exp_f_pat = 4'b0000;
`endif
    to_pos();
    i_fetch_addr = 32'h108;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h10C;
    for (int c = 0; c < 4; c++) begin
      to_neg();
      check("conf_data_gnt", o_data_gnt, exp_d_pat[c]);
      check("conf_fetch_gnt", o_fetch_gnt, exp_f_pat[c]);
      if (exp_d_pat[c]) data_q.push_back(ref_mem[67]);
      if (exp_f_pat[c]) fetch_q.push_back(ref_mem[66]);
      to_pos();
    end
    idle_inputs();
    to_neg();

    // Flush in the response cycle kills the fetch valid; concurrent data read proceeds.
    to_pos();
    i_fetch_req = 1'b1; i_fetch_addr = 32'h110;
    to_neg();
    check("fl_fetch_gnt", o_fetch_gnt, 1);
    fetch_q.push_back(ref_mem[68]);
    to_pos();
    i_fetch_flush = 1'b1;
    i_data_req = 1'b1; i_data_addr = 32'h114;
    to_neg();
    check("fl_fetch_valid", o_fetch_valid, 0);
    check("fl_fetch_gnt_blocked", o_fetch_gnt, 0);
    check("fl_data_gnt", o_data_gnt, 1);
    void'(fetch_q.pop_front());
    data_q.push_back(ref_mem[69]);
    to_pos();
    idle_inputs();
    to_neg();
    check("fl_data_valid", o_data_valid, 1);

    // Stall in the response cycle; response re-presented when enabled again.
    to_pos();
    i_fetch_req = 1'b1; i_fetch_addr = 32'h118;
    to_neg();
    check("st_gnt", o_fetch_gnt, 1);
    fetch_q.push_back(ref_mem[70]);
    to_pos();
    i_fetch_req = 1'b0; clk_en = 1'b0;
    i_data_req = 1'b1; i_data_addr = 32'h11C;
    to_neg();
    check("st_no_valid", o_fetch_valid, 0);
    check("st_ram_en", o_ram_en, 0);
    check("st_data_gnt", o_data_gnt, 0);
    to_pos();
    clk_en = 1'b1; i_data_req = 1'b0;
    to_neg();
    check("st_valid", o_fetch_valid, 1);

    // Async reset while a fetch response is pending.
    to_pos();
    i_fetch_req = 1'b1; i_fetch_addr = 32'h120;
    to_neg();
    check("rs_gnt", o_fetch_gnt, 1);
    fetch_q.push_back(ref_mem[72]);
    to_pos();
    rst = 1'b1;
    #1;
    check("rs_fetch_valid", o_fetch_valid, 0);
    check("rs_fetch_gnt", o_fetch_gnt, 0);
    check("rs_ram_en", o_ram_en, 0);
    void'(fetch_q.pop_front());
    to_pos();
    rst = 1'b0; i_fetch_req = 1'b0;
    to_neg();
    check("rs_no_valid_after", o_fetch_valid, 0);

    to_pos();
    to_neg();
    check("fetch_q_drained", fetch_q.size(), 0);
    check("data_q_drained", data_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
